// File: rtl/screen_pkg.sv
// Shared types and widths for the screen RAM arbiter and its read pipeline.
package screen_pkg;

    localparam int SCREEN_ADDR_W = 13;
    localparam int SCREEN_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_VGA    = 2'd1,
        OWN_CPU_RD = 2'd2,
        OWN_CPU_WR = 2'd3
    } owner_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CPU_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/screen_rd_pipe.sv
// Tracks which requester owns each RAM cycle and turns the 1-cycle RAM read
// latency into registered read data plus VALID/ACK strobes.
module screen_rd_pipe
    import screen_pkg::*;
#(
    parameter int DATA_W = SCREEN_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  owner_e            i_owner,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_vga_data,
    output logic              o_vga_valid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic              o_cpu_pending
);

    owner_e            r_tag;
    logic              r_vga_valid;
    logic              r_cpu_rd_ack;
    logic [DATA_W-1:0] r_vga_data;
    logic [DATA_W-1:0] r_cpu_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag        <= OWN_NONE;
            r_vga_valid  <= 1'b0;
            r_cpu_rd_ack <= 1'b0;
            r_vga_data   <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_tag        <= i_owner;
            r_vga_valid  <= (r_tag == OWN_VGA);
            r_cpu_rd_ack <= (r_tag == OWN_CPU_RD);
            // RAM data for the cycle owned by r_tag is on i_ram_rdata now
            if (r_tag == OWN_VGA)
                r_vga_data <= i_ram_rdata;
            if (r_tag == OWN_CPU_RD)
                r_cpu_rdata <= i_ram_rdata;
        end
    end

    assign o_vga_data    = r_vga_data;
    assign o_vga_valid   = r_vga_valid;
    assign o_cpu_rdata   = r_cpu_rdata;
    // Writes complete as soon as the RAM has taken them; reads need the capture stage
    assign o_cpu_ack     = r_cpu_rd_ack | (r_tag == OWN_CPU_WR);
    assign o_cpu_pending = r_cpu_rd_ack | (r_tag == OWN_CPU_RD) | (r_tag == OWN_CPU_WR);

endmodule

// File: rtl/screen_arbiter.sv
// Single-port screen RAM arbiter: VGA scan-out reads have absolute priority,
// CPU accesses are served one at a time with a req/ack handshake.
module screen_arbiter
    import screen_pkg::*;
#(
    parameter int ADDR_W   = SCREEN_ADDR_W,
    parameter int DATA_W   = SCREEN_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iVGA_REQ,
    input  logic [ADDR_W-1:0] iVGA_ADDR,
    output logic [DATA_W-1:0] oVGA_DATA,
    output logic              oVGA_VALID,
    input  logic              iCPU_REQ,
    input  logic              iCPU_WE,
    input  logic [ADDR_W-1:0] iCPU_ADDR,
    input  logic [DATA_W-1:0] iCPU_WDATA,
    output logic [DATA_W-1:0] oCPU_RDATA,
    output logic              oCPU_ACK,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic              oRAM_WE,
    output logic [DATA_W-1:0] oRAM_WDATA,
    input  logic [DATA_W-1:0] iRAM_RDATA,
    output logic              oSTARVE
);

    localparam logic [2:0] LP_MAX_WAIT = 3'(MAX_WAIT);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [2:0]        r_wait;
    logic [2:0]        w_wait_nxt;
    logic              r_starve;
    logic              w_vga_gnt;
    logic              w_cpu_gnt;
    logic              w_cpu_ack;
    logic              w_cpu_pending;
    owner_e            w_owner;

    // Grants are gated by reset so the RAM sees no traffic while held in reset
    always_comb begin
        w_vga_gnt  = iRST_N & iVGA_REQ;
        w_cpu_gnt  = iRST_N & ~iVGA_REQ & iCPU_REQ & (r_state == ST_IDLE) & ~w_cpu_pending;
        w_owner    = OWN_NONE;
        oRAM_ADDR  = r_addr_hold;
        oRAM_WE    = 1'b0;
        oRAM_WDATA = '0;
        if (w_vga_gnt) begin
            w_owner   = OWN_VGA;
            oRAM_ADDR = iVGA_ADDR;
        end else if (w_cpu_gnt) begin
            w_owner    = iCPU_WE ? OWN_CPU_WR : OWN_CPU_RD;
            oRAM_ADDR  = iCPU_ADDR;
            oRAM_WE    = iCPU_WE;
            oRAM_WDATA = iCPU_WDATA;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_cpu_gnt) w_state_nxt = ST_CPU_BUSY;
            ST_CPU_BUSY: if (w_cpu_ack) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_cpu_gnt)
            w_wait_nxt = 3'd0;
        else if (iCPU_REQ && (r_state == ST_IDLE) && (r_wait != 3'd7))
            w_wait_nxt = r_wait + 3'd1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= ST_IDLE;
            r_addr_hold <= '0;
            r_wait      <= 3'd0;
            r_starve    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_hold <= oRAM_ADDR;
            r_wait      <= w_wait_nxt;
            if (w_wait_nxt >= LP_MAX_WAIT)
                r_starve <= 1'b1;
        end
    end

    screen_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .i_clk         (iCLK),
        .i_rst_n       (iRST_N),
        .i_owner       (w_owner),
        .i_ram_rdata   (iRAM_RDATA),
        .o_vga_data    (oVGA_DATA),
        .o_vga_valid   (oVGA_VALID),
        .o_cpu_rdata   (oCPU_RDATA),
        .o_cpu_ack     (w_cpu_ack),
        .o_cpu_pending (w_cpu_pending)
    );

    assign oCPU_ACK = w_cpu_ack;
    assign oSTARVE  = r_starve;

endmodule

// File: tb/tb_screen_arbiter.sv
// Directed bench for screen_arbiter with a behavioural 8K x 16 synchronous RAM.
module tb_screen_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iVGA_REQ;
    logic [12:0] iVGA_ADDR;
    logic [15:0] oVGA_DATA;
    logic        oVGA_VALID;
    logic        iCPU_REQ;
    logic        iCPU_WE;
    logic [12:0] iCPU_ADDR;
    logic [15:0] iCPU_WDATA;
    logic [15:0] oCPU_RDATA;
    logic        oCPU_ACK;
    logic [12:0] oRAM_ADDR;
    logic        oRAM_WE;
    logic [15:0] oRAM_WDATA;
    logic [15:0] iRAM_RDATA;
    logic        oSTARVE;

    logic [15:0] mem [0:8191];
    logic        pre_we;
    logic [12:0] pre_addr;
    logic [15:0] pre_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 iCLK = ~iCLK;

    screen_arbiter #(.ADDR_W(13), .DATA_W(16), .MAX_WAIT(4)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iVGA_REQ   (iVGA_REQ),
        .iVGA_ADDR  (iVGA_ADDR),
        .oVGA_DATA  (oVGA_DATA),
        .oVGA_VALID (oVGA_VALID),
        .iCPU_REQ   (iCPU_REQ),
        .iCPU_WE    (iCPU_WE),
        .iCPU_ADDR  (iCPU_ADDR),
        .iCPU_WDATA (iCPU_WDATA),
        .oCPU_RDATA (oCPU_RDATA),
        .oCPU_ACK   (oCPU_ACK),
        .oRAM_ADDR  (oRAM_ADDR),
        .oRAM_WE    (oRAM_WE),
        .oRAM_WDATA (oRAM_WDATA),
        .iRAM_RDATA (iRAM_RDATA),
        .oSTARVE    (oSTARVE)
    );

    // Screen RAM model; pre_* is a bench-only backdoor used while the DUT is in reset
    always @(posedge iCLK) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (oRAM_WE)
            mem[oRAM_ADDR] <= oRAM_WDATA;
        iRAM_RDATA <= mem[oRAM_ADDR];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    int n_ack;

    initial begin
        iRST_N = 1'b0; iVGA_REQ = 1'b0; iVGA_ADDR = '0;
        iCPU_REQ = 1'b0; iCPU_WE = 1'b0; iCPU_ADDR = '0; iCPU_WDATA = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Preload while in reset; VGA request must not reach the RAM in reset
        cyc();
        pre_we = 1'b1; pre_addr = 13'h1234; pre_data = 16'h0ABC; iVGA_REQ = 1'b1; iVGA_ADDR = 13'h0FFF;
        #1;
        chk("rst_ram_addr", oRAM_ADDR, 0);
        chk("rst_ram_we", oRAM_WE, 0);
        cyc();
        iVGA_REQ = 1'b0; iVGA_ADDR = '0;
        pre_addr = 13'h0010; pre_data = 16'h1111;
        cyc();
        pre_addr = 13'h0020; pre_data = 16'h2222;
        cyc();
        pre_we = 1'b0;
        #1;
        chk("rst_outs", |{oVGA_DATA, oVGA_VALID, oCPU_RDATA, oCPU_ACK, oRAM_ADDR, oRAM_WE, oRAM_WDATA, oSTARVE}, 0);
        iRST_N = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_outs", |{oVGA_DATA, oVGA_VALID, oCPU_RDATA, oCPU_ACK, oRAM_ADDR, oRAM_WE, oRAM_WDATA, oSTARVE}, 0);
        end

        // VGA-only read
        iVGA_REQ = 1'b1; iVGA_ADDR = 13'h1234;
        #1;
        chk("vga_ram_addr", oRAM_ADDR, 13'h1234);
        chk("vga_ram_we", oRAM_WE, 0);
        cyc();
        iVGA_REQ = 1'b0; iVGA_ADDR = '0;
        #1;
        chk("vga_valid_n1", oVGA_VALID, 0);
        chk("vga_hold_addr", oRAM_ADDR, 13'h1234);
        cyc();
        chk("vga_valid_n2", oVGA_VALID, 1);
        chk("vga_data_n2", oVGA_DATA, 16'h0ABC);
        cyc();
        chk("vga_valid_n3", oVGA_VALID, 0);

        // CPU write then read back
        iCPU_REQ = 1'b1; iCPU_WE = 1'b1; iCPU_ADDR = 13'h0005; iCPU_WDATA = 16'hBEEF;
        #1;
        chk("wr_ram_we", oRAM_WE, 1);
        chk("wr_ram_addr", oRAM_ADDR, 13'h0005);
        chk("wr_ram_wdata", oRAM_WDATA, 16'hBEEF);
        chk("wr_ack_n0", oCPU_ACK, 0);
        cyc();
        chk("wr_ack_n1", oCPU_ACK, 1);
        chk("wr_ram_we_n1", oRAM_WE, 0);
        iCPU_REQ = 1'b0; iCPU_WE = 1'b0;
        cyc();
        chk("wr_ack_n2", oCPU_ACK, 0);
        chk("wr_ram_we_n2", oRAM_WE, 0);
        iCPU_REQ = 1'b1; iCPU_WE = 1'b0; iCPU_ADDR = 13'h0005;
        #1;
        chk("rd_ram_addr", oRAM_ADDR, 13'h0005);
        chk("rd_ram_we", oRAM_WE, 0);
        cyc();
        chk("rd_ack_n1", oCPU_ACK, 0);
        cyc();
        chk("rd_ack_n2", oCPU_ACK, 1);
        chk("rd_data", oCPU_RDATA, 16'hBEEF);
        iCPU_REQ = 1'b0;
        cyc();
        chk("rd_ack_n3", oCPU_ACK, 0);

        // Simultaneous VGA and CPU read: VGA first
        iVGA_REQ = 1'b1; iVGA_ADDR = 13'h0010;
        iCPU_REQ = 1'b1; iCPU_WE = 1'b0; iCPU_ADDR = 13'h0020;
        #1;
        chk("sim_n0_addr", oRAM_ADDR, 13'h0010);
        cyc();
        iVGA_REQ = 1'b0;
        #1;
        chk("sim_n1_addr", oRAM_ADDR, 13'h0020);
        chk("sim_n1_ack", oCPU_ACK, 0);
        cyc();
        chk("sim_n2_valid", oVGA_VALID, 1);
        chk("sim_n2_vdata", oVGA_DATA, 16'h1111);
        chk("sim_n2_ack", oCPU_ACK, 0);
        cyc();
        chk("sim_n3_ack", oCPU_ACK, 1);
        chk("sim_n3_rdata", oCPU_RDATA, 16'h2222);
        chk("sim_n3_valid", oVGA_VALID, 0);
        chk("sim_starve", oSTARVE, 0);
        iCPU_REQ = 1'b0;
        cyc();
        chk("sim_n4_ack", oCPU_ACK, 0);

        // Five back-to-back VGA cycles starve a held CPU write
        iCPU_REQ = 1'b1; iCPU_WE = 1'b1; iCPU_ADDR = 13'h0007; iCPU_WDATA = 16'h5A5A;
        for (int i = 0; i < 5; i++) begin
            iVGA_REQ = 1'b1; iVGA_ADDR = 13'h0100 + 13'(i);
            #1;
            chk("stv_vga_addr", oRAM_ADDR, 13'h0100 + 13'(i));
            chk("stv_we_low", oRAM_WE, 0);
            cyc();
        end
        iVGA_REQ = 1'b0; iVGA_ADDR = '0;
        #1;
        chk("stv_cpu_we", oRAM_WE, 1);
        chk("stv_cpu_addr", oRAM_ADDR, 13'h0007);
        chk("stv_flag", oSTARVE, 1);
        cyc();
        chk("stv_ack", oCPU_ACK, 1);
        iCPU_REQ = 1'b0; iCPU_WE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stv_sticky", oSTARVE, 1);
        end

        // Reset one cycle after a CPU read grant drops the transaction
        iCPU_REQ = 1'b1; iCPU_WE = 1'b0; iCPU_ADDR = 13'h0005;
        #1;
        chk("rst_rd_grant", oRAM_ADDR, 13'h0005);
        cyc();
        iRST_N = 1'b0; iCPU_REQ = 1'b0;
        #1;
        chk("rst_mid_ack", oCPU_ACK, 0);
        chk("rst_mid_starve", oSTARVE, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_no_ack", oCPU_ACK, 0);
        end
        iRST_N = 1'b1;
        cyc();
        chk("post_rst_ack", oCPU_ACK, 0);
        iCPU_REQ = 1'b1; iCPU_WE = 1'b0; iCPU_ADDR = 13'h0007;
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (oCPU_ACK) begin
                n_ack++;
                chk("post_rst_rdata", oCPU_RDATA, 16'h5A5A);
                iCPU_REQ = 1'b0;
            end
            cyc();
        end
        chk("post_rst_one_ack", n_ack, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
